// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// States SEND_H/WAIT_BH/WAIT_DH are only reachable when UART_SCHED_HDR_EN is defined.
package uart_pkg;

  localparam int CFG_W        = 5;
  localparam int CFG_LEN_LSB  = 0;
  localparam int CFG_LEN_MSB  = 1;
  localparam int CFG_PAR_EVEN = 2;
  localparam int CFG_PAR_EN   = 3;
  localparam int CFG_STOP_SEL = 4;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B,
    ST_WAIT_D,
    ST_SEND_H,
    ST_WAIT_BH,
    ST_WAIT_DH
  } sched_state_t;

  function automatic logic [7:0] hdr_byte(input logic [2:0] id);
    return {HDR_TAG, 1'b0, id};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider producing a registered single-cycle 16x tick.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_baud_div,
  output logic             o_clk16
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_clk16;
  logic [DIV_W-1:0] w_cnt_next;
  logic [DIV_W-1:0] w_div_m1;
  logic             w_div_small;
  logic             w_wrap;
  logic             w_tick_next;

  // Wrapping on >= lets a shrinking divisor take effect on the very next cycle.
  assign w_div_small = (i_baud_div <= DIV_W'(1));
  assign w_div_m1    = i_baud_div - DIV_W'(1);
  assign w_wrap      = w_div_small || (r_cnt >= w_div_m1);
  assign w_cnt_next  = w_wrap ? '0 : r_cnt + DIV_W'(1);
  assign w_tick_next = w_div_small || (w_cnt_next >= w_div_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_clk16 <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_clk16 <= w_tick_next;
    end
  end

  assign o_clk16 = r_clk16;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N requesters.
// Define UART_SCHED_HDR_EN to prefix every grant with a {HDR_TAG, 0, id} header byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DIV_W   = 16,
  parameter  int BUSY_TO = 8,
  localparam int ID_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       i_req_valid,
  input  logic [8*N-1:0]     i_req_data,
  input  logic [CFG_W*N-1:0] i_req_cfg,
  output logic [N-1:0]       o_req_ready,
  input  logic [DIV_W-1:0]   i_baud_div,
  output logic               o_clk16,
  output logic [7:0]         o_tx_data,
  output logic [CFG_W-1:0]   o_tx_cfg,
  output logic               o_tx_req,
  input  logic               i_tx_busy,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_active,
  output logic               o_to_err
);

  localparam int TO_W = $clog2(BUSY_TO + 1);

  sched_state_t     r_state, w_state_next;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [7:0]       r_tx_data;
  logic [CFG_W-1:0] r_tx_cfg;
  logic             r_tx_req;
  logic             r_to_err;
  logic [TO_W-1:0]  r_to_cnt;
`ifdef UART_SCHED_HDR_EN
  logic [7:0]       r_payload;
`endif

  logic [ID_W-1:0]  w_win;
  logic [7:0]       w_win_data;
  logic [CFG_W-1:0] w_win_cfg;
  logic [N-1:0]     w_req_ready;
  logic             w_capture;
  logic             w_load_payload;
  logic             w_timeout;
  logic             w_busy_expired;

  // Scan downwards so the nearest valid requester at or after ptr wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    pick = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign w_win          = rr_pick(i_req_valid, r_ptr);
  assign w_win_data     = i_req_data[8*w_win +: 8];
  assign w_win_cfg      = i_req_cfg[CFG_W*w_win +: CFG_W];
  assign w_busy_expired = (r_to_cnt == TO_W'(BUSY_TO - 1));

  always_comb begin
    w_state_next   = r_state;
    w_req_ready    = '0;
    w_capture      = 1'b0;
    w_load_payload = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req_valid) begin
          w_req_ready = N'(1) << w_win;
          w_capture   = 1'b1;
`ifdef UART_SCHED_HDR_EN
          w_state_next = ST_SEND_H;
`else
          w_state_next = ST_SEND;
`endif
        end
      end
      ST_SEND: w_state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_tx_busy) begin
          w_state_next = ST_WAIT_D;
        end else if (w_busy_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_D: if (!i_tx_busy) w_state_next = ST_IDLE;
`ifdef UART_SCHED_HDR_EN
      ST_SEND_H: w_state_next = ST_WAIT_BH;
      ST_WAIT_BH: begin
        if (i_tx_busy) begin
          w_state_next = ST_WAIT_DH;
        end else if (w_busy_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_DH: begin
        if (!i_tx_busy) begin
          w_load_payload = 1'b1;
          w_state_next   = ST_SEND;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The busy counter starts at 1 in the wait cycle after tx_req, so it tracks cycles since the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tx_cfg   <= '0;
      r_tx_req   <= 1'b0;
      r_to_err   <= 1'b0;
      r_to_cnt   <= '0;
`ifdef UART_SCHED_HDR_EN
      r_payload  <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_tx_req <= (w_state_next == ST_SEND) || (w_state_next == ST_SEND_H);
      if (w_capture) begin
        r_grant_id <= w_win;
        r_ptr      <= ID_W'((int'(w_win) + 1) % N);
        r_tx_cfg   <= w_win_cfg;
`ifdef UART_SCHED_HDR_EN
        r_tx_data  <= hdr_byte(3'(w_win));
        r_payload  <= w_win_data;
`else
        r_tx_data  <= w_win_data;
`endif
      end
`ifdef UART_SCHED_HDR_EN
      if (w_load_payload) r_tx_data <= r_payload;
`endif
      if (w_timeout) r_to_err <= 1'b1;
      if ((r_state == ST_SEND) || (r_state == ST_SEND_H)) begin
        r_to_cnt <= TO_W'(1);
      end else if ((r_state == ST_WAIT_B) || (r_state == ST_WAIT_BH)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk        (clk),
    .rst        (rst),
    .i_baud_div (i_baud_div),
    .o_clk16    (o_clk16)
  );

  assign o_req_ready = w_req_ready;
  assign o_tx_data   = r_tx_data;
  assign o_tx_cfg    = r_tx_cfg;
  assign o_tx_req    = r_tx_req;
  assign o_grant_id  = r_grant_id;
  assign o_active    = (r_state != ST_IDLE);
  assign o_to_err    = r_to_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (N=4, BUSY_TO=8, baud_div=4).
// Follows the header flow when compiled with UART_SCHED_HDR_EN.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [19:0] req_cfg;
  logic [3:0]  req_ready;
  logic [15:0] baud_div;
  logic        clk16;
  logic [7:0]  tx_data;
  logic [4:0]  tx_cfg;
  logic        tx_req;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        to_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] laneData [4] = '{8'h55, 8'h2B, 8'h3C, 8'h4D};
  logic [4:0] laneCfg  [4] = '{5'b00011, 5'b11001, 5'b01010, 5'b10111};

  uart_tx_sched #(.N(4), .DIV_W(16), .BUSY_TO(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_cfg   (req_cfg),
    .o_req_ready (req_ready),
    .i_baud_div  (baud_div),
    .o_clk16     (clk16),
    .o_tx_data   (tx_data),
    .o_tx_cfg    (tx_cfg),
    .o_tx_req    (tx_req),
    .i_tx_busy   (tx_busy),
    .o_grant_id  (grant_id),
    .o_active    (active),
    .o_to_err    (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restoreLanes();
    req_data = {laneData[3], laneData[2], laneData[1], laneData[0]};
    req_cfg  = {laneCfg[3], laneCfg[2], laneCfg[1], laneCfg[0]};
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    req_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete grant with a well-behaved transmitter, starting in an IDLE cycle.
  task automatic runGrant(input logic [3:0] v, input int expId, input string tag);
    applyStimulus(v);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1) << expId);
    tick();
`ifdef UART_SCHED_HDR_EN
    checkOutput({tag, "_hdr_req"}, 32'(tx_req), 32'd1);
    checkOutput({tag, "_hdr_data"}, 32'(tx_data), {24'h0, 4'hA, 1'b0, 3'(expId)});
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
`endif
    checkOutput({tag, "_tx_req"}, 32'(tx_req), 32'd1);
    checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'(laneData[expId]));
    checkOutput({tag, "_tx_cfg"}, 32'(tx_cfg), 32'(laneCfg[expId]));
    checkOutput({tag, "_grant"}, 32'(grant_id), 32'(expId));
    checkOutput({tag, "_ready_off"}, 32'(req_ready), 32'd0);
    tick();
    checkOutput({tag, "_req_drop"}, 32'(tx_req), 32'd0);
    tx_busy = 1'b1;
    tick();
    req_data = ~req_data;
    req_cfg  = ~req_cfg;
    #1;
    checkOutput({tag, "_hold_data"}, 32'(tx_data), 32'(laneData[expId]));
    checkOutput({tag, "_hold_cfg"}, 32'(tx_cfg), 32'(laneCfg[expId]));
    checkOutput({tag, "_active"}, 32'(active), 32'd1);
    restoreLanes();
    tx_busy = 1'b0;
    tick();
    checkOutput({tag, "_idle"}, 32'(active), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    tx_busy   = 1'b0;
    baud_div  = 16'd4;
    restoreLanes();
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_req", 32'(tx_req), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_cfg", 32'(tx_cfg), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_to_err", 32'(to_err), 32'd0);
    checkOutput("rst_clk16", 32'(clk16), 32'd0);
    rst = 1'b0;

    $display("[TB] clk16 with baud_div=4");
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("clk16_%0d", k), 32'(clk16), (k % 4 == 3) ? 32'd1 : 32'd0);
    end

    $display("[TB] single request");
    runGrant(4'b0001, 0, "single");
    applyStimulus(4'b0000);

    $display("[TB] fairness from a fresh pointer");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      runGrant(4'b1111, g % 4, $sformatf("fair%0d", g));
    end

    $display("[TB] pointer skip");
    runGrant(4'b0010, 1, "skip_pre");
    runGrant(4'b1010, 3, "skip_a");
    runGrant(4'b1010, 1, "skip_b");

    $display("[TB] busy timeout");
    applyStimulus(4'b0001);
    #1;
    checkOutput("to_ready", 32'(req_ready), 32'b0001);
    tick();
    checkOutput("to_tx_req", 32'(tx_req), 32'd1);
    applyStimulus(4'b0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("to_err_%0d", k), 32'(to_err), (k == 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to_active_%0d", k), 32'(active), (k == 8) ? 32'd0 : 32'd1);
    end
    runGrant(4'b0010, 1, "after_to");
    checkOutput("to_sticky", 32'(to_err), 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(4'b0100);
    #1;
    checkOutput("mid_ready", 32'(req_ready), 32'b0100);
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    checkOutput("mid_active_pre", 32'(active), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_tx_req", 32'(tx_req), 32'd0);
    checkOutput("mid_active", 32'(active), 32'd0);
    checkOutput("mid_to_err", 32'(to_err), 32'd0);
    checkOutput("mid_tx_data", 32'(tx_data), 32'd0);
    checkOutput("mid_grant", 32'(grant_id), 32'd0);
    checkOutput("mid_clk16", 32'(clk16), 32'd0);
    tx_busy = 1'b0;
    applyStimulus(4'b0000);
    tick();
    rst = 1'b0;
    applyStimulus(4'b1111);
    #1;
    checkOutput("mid_ptr_zero", 32'(req_ready), 32'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
